alarm_tick_master: RTL and testbench

- Avalon-MM initiator that programs and services the system interval timer slave: 16-bit data, 3-bit word address, no waitrequest, readdata registered in the slave.
- Loads a period, starts the timer in continuous mode with interrupts, and acknowledges each timeout.
- Divides timeouts into a seconds-of-day count for the alarm-clock logic.
- Captures counter snapshots on request.

---
 rtl/alarm_tick_master.sv | 162 ++++++++++++++++
 tb/tb_alarm_tick_master.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_tick_master.sv
// rtl/alarm_tick_master.sv - Avalon-MM initiator that programs and services an interval timer
// and divides its timeouts into a seconds-of-day count.
module alarm_tick_master #(
    parameter longint unsigned PERIOD        = 50000,
    parameter int unsigned     TICKS_PER_SEC = 1000,
    parameter int unsigned     SEC_PER_DAY   = 86400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        snap_req,
    output logic        busy,
    output logic        running,
    output logic        sec_tick,
    output logic [16:0] seconds_of_day,
    output logic        snap_valid,
    output logic [31:0] snap_value,
    output logic [2:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [15:0] av_writedata,
    input  logic [15:0] av_readdata,
    input  logic        av_irq
);

    localparam logic [31:0] PERIOD_M1 = 32'(PERIOD - 1);
    localparam logic [31:0] TICK_LAST = 32'(TICKS_PER_SEC - 1);
    localparam logic [16:0] SEC_LAST  = 17'(SEC_PER_DAY - 1);

    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_IRQ, SNAP_WR,
        SNAP_RL0, SNAP_RL1, SNAP_RH0, SNAP_RH1, STOP_WR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic [16:0] sec_q, sec_d;
    logic        sec_tick_q, sec_tick_d;
    logic [15:0] snap_lo_q, snap_lo_d;
    logic [31:0] snap_value_q, snap_value_d;
    logic        snap_valid_q, snap_valid_d;
    logic        cs_q, cs_d;
    logic        wn_q, wn_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        running_q, running_d;

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        sec_d        = sec_q;
        sec_tick_d   = 1'b0;
        snap_lo_d    = snap_lo_q;
        snap_value_d = snap_value_q;
        snap_valid_d = 1'b0;

        case (state_q)
            IDLE:     if (start) state_d = WR_PL;
            WR_PL:    state_d = WR_PH;
            WR_PH:    state_d = WR_CTRL;
            WR_CTRL:  state_d = RUN;
            RUN: begin
                // Pulses are not queued: a lower-priority request in the same cycle is lost.
                if (av_irq)        state_d = CLR_IRQ;
                else if (stop)     state_d = STOP_WR;
                else if (snap_req) state_d = SNAP_WR;
            end
            CLR_IRQ:  state_d = RUN;
            SNAP_WR:  state_d = SNAP_RL0;
            SNAP_RL0: state_d = SNAP_RL1;
            SNAP_RL1: begin
                state_d   = SNAP_RH0;
                snap_lo_d = av_readdata;
            end
            SNAP_RH0: state_d = SNAP_RH1;
            SNAP_RH1: begin
                state_d      = RUN;
                snap_value_d = {av_readdata, snap_lo_q};
                snap_valid_d = 1'b1;
            end
            STOP_WR:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Count the timeout in the same cycle its status-clear write is on the bus.
        if (state_d == CLR_IRQ) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d = 32'd0;
                sec_tick_d = 1'b1;
                sec_d      = (sec_q == SEC_LAST) ? 17'd0 : sec_q + 17'd1;
            end else begin
                tick_cnt_d = tick_cnt_q + 32'd1;
            end
        end

        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = 3'd0;
        wdata_d = 16'd0;
        case (state_d)
            WR_PL:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wdata_d = PERIOD_M1[15:0];  end
            WR_PH:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wdata_d = PERIOD_M1[31:16]; end
            WR_CTRL:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0007; end
            CLR_IRQ:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; end
            SNAP_WR:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4; end
            SNAP_RL0, SNAP_RL1: begin cs_d = 1'b1; addr_d = 3'd4; end
            SNAP_RH0, SNAP_RH1: begin cs_d = 1'b1; addr_d = 3'd5; end
            STOP_WR:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0008; end
            default:  ;
        endcase

        busy_d    = !(state_d == IDLE || state_d == RUN);
        running_d = (state_d inside {RUN, CLR_IRQ, SNAP_WR, SNAP_RL0, SNAP_RL1,
                                     SNAP_RH0, SNAP_RH1});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tick_cnt_q   <= 32'd0;
            sec_q        <= 17'd0;
            sec_tick_q   <= 1'b0;
            snap_lo_q    <= 16'd0;
            snap_value_q <= 32'd0;
            snap_valid_q <= 1'b0;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            addr_q       <= 3'd0;
            wdata_q      <= 16'd0;
            busy_q       <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            sec_q        <= sec_d;
            sec_tick_q   <= sec_tick_d;
            snap_lo_q    <= snap_lo_d;
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
            cs_q         <= cs_d;
            wn_q         <= wn_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
            running_q    <= running_d;
        end
    end

    assign busy           = busy_q;
    assign running        = running_q;
    assign sec_tick       = sec_tick_q;
    assign seconds_of_day = sec_q;
    assign snap_valid     = snap_valid_q;
    assign snap_value     = snap_value_q;
    assign av_address     = addr_q;
    assign av_chipselect  = cs_q;
    assign av_write_n     = wn_q;
    assign av_writedata   = wdata_q;

endmodule

// File: tb/tb_alarm_tick_master.sv
// tb/tb_alarm_tick_master.sv - Bench with interval timer model and write scoreboard for alarm_tick_master.
module tb_alarm_tick_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        snap_req = 1'b0;
    logic        busy, running, sec_tick, snap_valid;
    logic [16:0] seconds_of_day;
    logic [31:0] snap_value;
    logic [2:0]  av_address;
    logic        av_chipselect, av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata;
    logic        av_irq;

    always #5 clk = ~clk;

    alarm_tick_master #(.PERIOD(10), .TICKS_PER_SEC(4), .SEC_PER_DAY(3)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .snap_req(snap_req),
        .busy(busy), .running(running), .sec_tick(sec_tick),
        .seconds_of_day(seconds_of_day), .snap_valid(snap_valid), .snap_value(snap_value),
        .av_address(av_address), .av_chipselect(av_chipselect), .av_write_n(av_write_n),
        .av_writedata(av_writedata), .av_readdata(av_readdata), .av_irq(av_irq)
    );

    // Interval timer slave model
    logic [31:0] t_per = 32'd0, t_cnt = 32'd0, t_snap = 32'd0;
    logic        t_run = 1'b0, t_cont = 1'b0, t_ito = 1'b0, t_to = 1'b0;
    logic [15:0] t_rd = 16'd0;
    logic        t_wr, t_go;

    assign t_wr        = av_chipselect && !av_write_n;
    assign t_go        = t_wr && av_address == 3'd1 && av_writedata[2];
    assign av_irq      = t_to && t_ito;
    assign av_readdata = t_rd;

    always @(posedge clk) begin
        if (t_wr) begin
            case (av_address)
                3'd0: t_to <= 1'b0;
                3'd1: begin
                    t_ito  <= av_writedata[0];
                    t_cont <= av_writedata[1];
                    if (av_writedata[2]) begin t_run <= 1'b1; t_cnt <= t_per; end
                    if (av_writedata[3]) t_run <= 1'b0;
                end
                3'd2: t_per[15:0]  <= av_writedata;
                3'd3: t_per[31:16] <= av_writedata;
                3'd4, 3'd5: t_snap <= t_cnt;
                default: ;
            endcase
        end
        if (t_run && !t_go) begin
            if (t_cnt == 32'd0) begin
                t_to  <= 1'b1;
                t_cnt <= t_per;
                if (!t_cont) t_run <= 1'b0;
            end else begin
                t_cnt <= t_cnt - 32'd1;
            end
        end
        case (av_address)
            3'd4:    t_rd <= t_snap[15:0];
            3'd5:    t_rd <= t_snap[31:16];
            default: t_rd <= 16'd0;
        endcase
    end

    typedef struct { int cs; int wn; int a; int d; int busy; int run; } bus_vec_t;
    typedef struct { int tick; int sec; } tick_vec_t;

    bus_vec_t    pv[4];
    tick_vec_t   tv[12];
    logic [18:0] exp_q[$];
    int          n_chk = 0, n_err = 0;
    int          m_tick = 0, m_sec = 0, lat = 0;
    logic        irq_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of bus monitoring: irq rises queue a status write, writes are popped and checked.
    task automatic step();
        logic [18:0] e;
        @(negedge clk);
        if (reset) begin m_tick = 0; m_sec = 0; end
        if (av_irq && !irq_prev) begin
            exp_q.push_back(19'd0);
            lat = 0;
        end else begin
            lat++;
        end
        irq_prev = av_irq;
        if (av_chipselect && !av_write_n) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'({av_address, av_writedata}), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("bus_write", 32'({av_address, av_writedata}), 32'(e));
                if (av_address == 3'd0) begin
                    if (m_tick == 3) begin
                        m_tick = 0;
                        m_sec  = (m_sec + 1) % 3;
                        chk("model_sec_tick", 32'(sec_tick), 1);
                    end else begin
                        m_tick++;
                        chk("model_sec_tick", 32'(sec_tick), 0);
                    end
                    chk("model_seconds", 32'(seconds_of_day), 32'(m_sec));
                end
            end
        end
    endtask

    task automatic wait_status(input int lim, output bit found);
        found = 1'b0;
        for (int c = 0; c < lim && !found; c++) begin
            step();
            if (av_chipselect && !av_write_n && av_address == 3'd0) found = 1'b1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        exp_q.push_back({3'd2, 16'h0009});
        exp_q.push_back({3'd3, 16'h0000});
        exp_q.push_back({3'd1, 16'h0007});
        for (int i = 0; i < 4; i++) begin
            step();
            start = 1'b0;
            chk("prog_cs", 32'(av_chipselect), 32'(pv[i].cs));
            chk("prog_wn", 32'(av_write_n), 32'(pv[i].wn));
            if (pv[i].cs != 0) begin
                chk("prog_addr", 32'(av_address), 32'(pv[i].a));
                chk("prog_data", 32'(av_writedata), 32'(pv[i].d));
            end
            chk("prog_busy", 32'(busy), 32'(pv[i].busy));
            chk("prog_running", 32'(running), 32'(pv[i].run));
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_bus"}, 32'({av_chipselect, av_write_n, av_address, av_writedata}),
            32'({1'b0, 1'b1, 3'd0, 16'd0}));
        chk({nm, "_status"}, 32'({busy, running, sec_tick, snap_valid}), 0);
        chk({nm, "_seconds"}, 32'(seconds_of_day), 0);
        chk({nm, "_snap_value"}, snap_value, 0);
    endtask

    initial begin
        bit found, seen_irq;

        pv[0] = '{1, 0, 2, 16'h0009, 1, 0};
        pv[1] = '{1, 0, 3, 16'h0000, 1, 0};
        pv[2] = '{1, 0, 1, 16'h0007, 1, 0};
        pv[3] = '{0, 1, 0, 0, 0, 1};
        tv[0]  = '{0, 0}; tv[1]  = '{0, 0}; tv[2]  = '{0, 0}; tv[3]  = '{1, 1};
        tv[4]  = '{0, 1}; tv[5]  = '{0, 1}; tv[6]  = '{0, 1}; tv[7]  = '{1, 2};
        tv[8]  = '{0, 2}; tv[9]  = '{0, 2}; tv[10] = '{0, 2}; tv[11] = '{1, 0};

        repeat (3) step();
        reset = 1'b0;
        step();
        chk_reset_vals("reset");

        // stop and snap_req are ignored in IDLE
        stop = 1'b1; snap_req = 1'b1;
        step();
        stop = 1'b0; snap_req = 1'b0;
        step();
        chk("idle_ignore", 32'({busy, running, av_chipselect}), 0);

        do_start();

        for (int i = 0; i < 12; i++) begin
            wait_status(30, found);
            chk("timeout_seen", 32'(found), 1);
            chk("irq_latency_ok", 32'(lat <= 2), 1);
            chk("tv_sec_tick", 32'(sec_tick), 32'(tv[i].tick));
            chk("tv_seconds", 32'(seconds_of_day), 32'(tv[i].sec));
            chk("tv_running", 32'(running), 1);
        end

        // Snapshot placed so the next timeout lands inside the read sequence
        repeat (5) step();
        snap_req = 1'b1;
        exp_q.push_back({3'd4, 16'h0000});
        step();
        snap_req = 1'b0;
        chk("snap_wr", 32'({av_chipselect, av_write_n, av_address}), 32'({1'b1, 1'b0, 3'd4}));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("snap_rd", 32'({av_chipselect, av_write_n, av_address}),
                32'({1'b1, 1'b1, (i < 2) ? 3'd4 : 3'd5}));
            chk("snap_rd_busy", 32'({busy, running, snap_valid}), 32'(3'b110));
        end
        step();
        chk("snap_valid", 32'(snap_valid), 1);
        chk("snap_value", snap_value, t_snap);
        chk("snap_le_9", 32'(snap_value <= 32'd9), 1);
        chk("snap_running", 32'({busy, running}), 32'(2'b01));
        wait_status(5, found);
        chk("snap_valid_pulse", 32'(snap_valid), 0);
        chk("irq_after_snap", 32'(found), 1);

        // Stop from RUN
        step();
        stop = 1'b1;
        exp_q.push_back({3'd1, 16'h0008});
        step();
        stop = 1'b0;
        chk("stop_wr", 32'({av_chipselect, av_write_n, av_address, av_writedata}),
            32'({1'b1, 1'b0, 3'd1, 16'h0008}));
        chk("stop_wr_status", 32'({busy, running}), 32'(2'b10));
        step();
        chk("stop_idle", 32'({busy, running, av_chipselect}), 0);
        seen_irq = 1'b0;
        repeat (30) begin
            step();
            if (av_irq) seen_irq = 1'b1;
        end
        chk("irq_masked", 32'(seen_irq), 0);

        // Restart resumes from the held counts
        do_start();
        chk("held_seconds", 32'(seconds_of_day), 32'(m_sec));
        for (int i = 0; i < 3; i++) begin
            wait_status(30, found);
            chk("resume_seen", 32'(found), 1);
        end
        chk("resume_sec_tick", 32'(sec_tick), 1);
        chk("resume_seconds", 32'(seconds_of_day), 1);

        // Same-cycle irq and stop: irq wins, stop dropped
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            step();
            if (av_irq) found = 1'b1;
        end
        chk("irq_rise_seen", 32'(found), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("irq_vs_stop_clr", 32'({av_chipselect, av_write_n, av_address}), 32'({1'b1, 1'b0, 3'd0}));
        step();
        chk("irq_vs_stop_run", 32'({busy, running, av_chipselect}), 32'(3'b010));
        step();
        chk("stop_dropped", 32'({busy, running, av_chipselect}), 32'(3'b010));

        // Reset during WR_PH
        stop = 1'b1;
        exp_q.push_back({3'd1, 16'h0008});
        step();
        stop = 1'b0;
        step();
        start = 1'b1;
        exp_q.push_back({3'd2, 16'h0009});
        exp_q.push_back({3'd3, 16'h0000});
        step();
        start = 1'b0;
        step();
        chk("in_wr_ph", 32'({av_chipselect, av_address}), 32'({1'b1, 3'd3}));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_vals("mid_reset");
        repeat (3) step();
        chk("post_reset_idle", 32'({av_chipselect, av_write_n, busy}), 32'(3'b010));
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule
